mem_access_ctrl: RTL

//  Memory-side controller sitting between the datapath (MAR/MDR requests) and the
//  512x32 RAM. Accepts one read/write request via valid/ready handshake, latches

---
 rtl/mem_access_ctrl_if.sv | 35 +++
 rtl/mem_access_ctrl.sv | 122 ++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake and RAM strobe bus for mem_access_ctrl.
// The master side is the datapath plus the RAM. The slave side is the controller.
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [31:0]       req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    logic              ram_read;
    logic              ram_write;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_mdatain;
    logic [DATA_W-1:0] ram_data_output;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready, ram_data_output,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               ram_read, ram_write, ram_address, ram_mdatain
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready, ram_data_output,
        output req_ready, resp_valid, resp_rdata, resp_err,
               ram_read, ram_write, ram_address, ram_mdatain
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-outstanding RAM access controller: IDLE -> ACCESS (ACC_CYCLES strobe window) -> RESP.
// Optional MEM_RANGE_CHECK_EN: out-of-range word addresses skip the RAM and return resp_err=1.
module mem_access_ctrl #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 32,
    parameter int ACC_CYCLES = 2
) (
    input logic              Clock,
    input logic              Reset_n,
    mem_access_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(ACC_CYCLES) + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              write_q, write_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic              out_of_range;

`ifdef MEM_RANGE_CHECK_EN
    assign out_of_range = |bus.req_addr[31:ADDR_W];
`else
    // Upper address bits are deliberately dropped: the RAM sees the truncated word address.
    logic unused_addr_hi;
    assign unused_addr_hi = |bus.req_addr[31:ADDR_W];
    assign out_of_range   = 1'b0;
`endif

    always_comb begin
        // NOTE: every next-state signal starts from its current value so no branch can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        write_d = write_q;
        ready_d = ready_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (ready_q && bus.req_valid) begin
                    addr_d  = bus.req_addr[ADDR_W-1:0];
                    wdata_d = bus.req_wdata;
                    write_d = bus.req_write;
                    ready_d = 1'b0;
                    if (out_of_range) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = ST_RESP;
                    end else begin
                        err_d   = 1'b0;
                        cnt_d   = CNT_W'(ACC_CYCLES - 1);
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    rdata_d = write_q ? '0 : bus.ram_data_output;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                // A request arriving alongside resp_ready waits for IDLE; no bypass path.
                if (bus.resp_ready) begin
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            write_q <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking only, so every register samples pre-edge values of the others.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            write_q <= write_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // Strobes and resp_valid decode straight from state so an async reset drops them at once.
    assign bus.req_ready   = ready_q;
    assign bus.resp_valid  = (state_q == ST_RESP);
    assign bus.resp_rdata  = rdata_q;
    assign bus.resp_err    = err_q;
    assign bus.ram_read    = (state_q == ST_ACCESS) && !write_q;
    assign bus.ram_write   = (state_q == ST_ACCESS) && write_q;
    assign bus.ram_address = addr_q;
    assign bus.ram_mdatain = wdata_q;
endmodule
